regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8x8-bit register file among NREQ requesters (e.g. ALU writeback, load unit, debug port).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives a registered RegWrite/write_reg/write_data triple into the register file.
- Also provides read-after-write hazard flags and forwarding for the pending write, plus a sequenced scrub that writes a fill value to all 8 registers.

Parameters:
- NREQ, 3, number of write requesters (2..4).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  per-requester write request.
- req_ready  output  NREQ  per-requester grant; a transfer occurs when valid and ready are both high.
- req_addr  input  3*NREQ  flattened destination addresses; requester i uses bits [3i+2:3i].
- req_data  input  8*NREQ  flattened write data; requester i uses bits [8i+7:8i].
- stall  input  1  register-file side hold; no new grants while high.
- scrub_start  input  1  pulse: start the fill sequence.
- scrub_value  input  8  fill data, sampled on the scrub_start acceptance cycle.
- scrub_busy  output  1  high while the scrub sequence runs.
- rf_we  output  1  to RegWrite.
- rf_waddr  output  3  to write_reg.
- rf_wdata  output  8  to write_data.
- rd1_addr, rd2_addr  input  3 each  copies of the register file read addresses.
- rd1_hazard, rd2_hazard  output  1 each  the read address matches the write currently presented (rf_we=1).
- rd1_fwd, rd2_fwd  output  8 each  rf_wdata when the corresponding hazard is high, else 0.

Behaviour:
- Reset (async) values:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - req_ready=0, scrub_busy=0.
  - Round-robin pointer=0; FSM=IDLE; scrub counter=0; latched fill value=0.
- FSM states: IDLE, ARB, SCRUB.
  - IDLE→ARB on the first clock after reset release.
  - ARB→SCRUB when scrub_start=1 and stall=0. scrub_start is ignored while in SCRUB.
  - SCRUB→ARB after the write to address 7 is issued.
- ARB, combinational grant:
  - If stall=0, exactly one req_ready is high: the first valid requester at or after the pointer, cyclically.
  - req_ready is 0 for all requesters when none is valid, when stall=1, or when not in ARB.
  - req_ready never depends on req_ready.
- Transfer (ARB):
  - On a transfer from requester g: next cycle rf_we=1, rf_waddr=req_addr[g], rf_wdata=req_data[g].
  - The pointer becomes (g+1) mod NREQ.
  - Latency from grant to RegWrite is 1 cycle. With no transfer, rf_we=0 on the next cycle.
- scrub_start priority: scrub_start beats pending requests on the same cycle. No grant is issued on that cycle.
- SCRUB:
  - Issues one write per non-stalled cycle: addresses 0..7 in order, data = latched scrub_value.
  - scrub_busy=1 from the cycle after acceptance through the cycle rf_we presents address 7.
  - Requesters get no grants during SCRUB. Their valid must stay held (standard rule: valid and payload stable until ready).
- stall handling:
  - While stall=1, rf_we/rf_waddr/rf_wdata hold their current values.
  - A write presented during stall is re-presented, not duplicated: the register file rewrites the same value, so this is harmless and allowed.
  - The scrub counter does not advance while stall=1.
- Hazard/forward:
  - Purely combinational from rf_we/rf_waddr/rf_wdata and rd*_addr.
  - Both read ports may hit the same address simultaneously.
- Reset mid-scrub: immediate abort; all outputs go to reset values; the scrub does not resume.
- Pointer wrap: pointer at NREQ-1 with a grant wraps to 0.
- Unsupported parameter values: NREQ outside 2..4 is unsupported; elaborate with an error.

Test Plan:
- Reset values: reset asserted mid-cycle → all outputs 0 immediately (async); first grant possible 2 cycles after release.
- Single requester: req1 valid, addr=5, data=0xA7 → req_ready[1]=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xA7; rd1_addr=5 gives rd1_hazard=1, rd1_fwd=0xA7.
- Fairness: all 3 valid continuously for 6 cycles → grant order 0,1,2,0,1,2; after a grant to 2, the pointer wraps to 0.
- Stall: transfer from req0 (addr=3, data=0x11), then stall=1 for 3 cycles → rf_* hold 3/0x11, req_ready all 0; after stall drops, grant resumes with req1.
- Scrub: scrub_start with scrub_value=0x5A while req2 valid → no grant that cycle; rf_we writes addresses 0..7 with 0x5A on 8 consecutive cycles; scrub_busy high for exactly those 8 cycles; req2 granted after.
- Reset mid-scrub: reset asserted at address 4 → outputs cleared, FSM back to IDLE; subsequent requests are arbitrated starting from pointer 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// NREQ requesters use valid/ready handshakes. The winning write is registered
// onto rf_we/rf_waddr/rf_wdata. The block also provides read-after-write
// hazard flags with forwarding, and a sequenced scrub that fills all 8
// registers with one value.
module regfile_write_arbiter #(
    parameter int NREQ = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_data,
    input  logic              stall,
    input  logic              scrub_start,
    input  logic [7:0]        scrub_value,
    output logic              scrub_busy,
    output logic              rf_we,
    output logic [2:0]        rf_waddr,
    output logic [7:0]        rf_wdata,
    input  logic [2:0]        rd1_addr,
    input  logic [2:0]        rd2_addr,
    output logic              rd1_hazard,
    output logic              rd2_hazard,
    output logic [7:0]        rd1_fwd,
    output logic [7:0]        rd2_fwd
);

    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("regfile_write_arbiter: NREQ must be in 2..4");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        SCRUB = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] fill_q, fill_d;
    logic       rf_we_q, rf_we_d;
    logic [2:0] rf_waddr_q, rf_waddr_d;
    logic [7:0] rf_wdata_q, rf_wdata_d;
    logic       scrub_busy_q, scrub_busy_d;

    logic       found;
    logic [1:0] gidx;
    logic [2:0] idx;
    logic       arb_ok;
    logic       grant_en;
    logic [2:0] sel_addr;
    logic [7:0] sel_data;

    // Find the first valid requester at or after the pointer, cyclically
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + 3'(k);
            if (idx >= 3'(NREQ))
                idx = idx - 3'(NREQ);
            if (!found && req_valid[idx[1:0]]) begin
                found = 1'b1;
                gidx  = idx[1:0];
            end
        end
    end

    // A grant needs ARB, no stall, and no scrub request taking the cycle
    assign arb_ok   = (state_q == ARB) && !stall;
    assign grant_en = arb_ok && !scrub_start && found;

    // One-hot ready for the winner. This depends only on valid, not on ready.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = grant_en && (gidx == 2'(i));
    end

    // Route the winner's payload to the write port
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == 2'(i)) begin
                sel_addr = req_addr[3*i +: 3];
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic. Stall freezes everything.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        fill_d       = fill_q;
        rf_we_d      = rf_we_q;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        scrub_busy_d = scrub_busy_q;
        case (state_q)
            IDLE: begin
                state_d = ARB;
            end
            ARB: begin
                if (arb_ok) begin
                    rf_we_d      = 1'b0;
                    scrub_busy_d = 1'b0;
                    if (scrub_start) begin
                        // Address 0 goes out immediately, so busy covers
                        // exactly the eight cycles that present scrub writes.
                        state_d      = SCRUB;
                        fill_d       = scrub_value;
                        cnt_d        = 3'd1;
                        rf_we_d      = 1'b1;
                        rf_waddr_d   = 3'd0;
                        rf_wdata_d   = scrub_value;
                        scrub_busy_d = 1'b1;
                    end else if (found) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = sel_addr;
                        rf_wdata_d = sel_data;
                        ptr_d      = (gidx == 2'(NREQ-1)) ? 2'd0 : gidx + 2'd1;
                    end
                end
            end
            SCRUB: begin
                if (!stall) begin
                    rf_we_d      = 1'b1;
                    rf_waddr_d   = cnt_q;
                    rf_wdata_d   = fill_q;
                    scrub_busy_d = 1'b1;
                    cnt_d        = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ARB;
                        cnt_d   = 3'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset aborts any scrub in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            fill_q       <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            scrub_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            fill_q       <= fill_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            scrub_busy_q <= scrub_busy_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign scrub_busy = scrub_busy_q;

    // Hazard and forwarding against the write currently on the port
    assign rd1_hazard = rf_we_q && (rd1_addr == rf_waddr_q);
    assign rd2_hazard = rf_we_q && (rd2_addr == rf_waddr_q);
    assign rd1_fwd    = rd1_hazard ? rf_wdata_q : 8'h00;
    assign rd2_fwd    = rd2_hazard ? rf_wdata_q : 8'h00;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed stimulus with literal checks, plus
// a per-cycle comparison against a queue-based behavioural model.
module tb_regfile_write_arbiter;
    localparam int NREQ = 3;
    localparam int W    = NREQ + 33;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_data;
    logic              stall;
    logic              scrub_start;
    logic [7:0]        scrub_value;
    logic              scrub_busy;
    logic              rf_we;
    logic [2:0]        rf_waddr;
    logic [7:0]        rf_wdata;
    logic [2:0]        rd1_addr, rd2_addr;
    logic              rd1_hazard, rd2_hazard;
    logic [7:0]        rd1_fwd, rd2_fwd;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_write_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .stall(stall), .scrub_start(scrub_start), .scrub_value(scrub_value),
        .scrub_busy(scrub_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_hazard(rd1_hazard), .rd2_hazard(rd2_hazard),
        .rd1_fwd(rd1_fwd), .rd2_fwd(rd2_fwd)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The port presents the last issued write. A scrub is a queue of eight
    // pending writes that the port drains before any requester is served.
    logic        m_run;
    int          m_ptr;
    logic        m_we;
    logic [2:0]  m_waddr;
    logic [7:0]  m_wdata;
    logic        m_busy;
    logic [10:0] sq[$];

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        logic hit;
        r = '0;
        hit = 1'b0;
        if (m_run && sq.size() == 0 && !stall && !scrub_start) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!hit && req_valid[(m_ptr + k) % NREQ]) begin
                    r[(m_ptr + k) % NREQ] = 1'b1;
                    hit = 1'b1;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [NREQ-1:0] r;
        logic [10:0] e;
        if (reset) begin
            m_run = 1'b0; m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
            m_busy = 1'b0;
            sq.delete();
        end else if (!m_run) begin
            m_run = 1'b1;
        end else if (!stall) begin
            r = exp_ready();
            if (sq.size() == 0 && scrub_start) begin
                for (int a = 0; a < 8; a++) sq.push_back({3'(a), scrub_value});
            end
            if (sq.size() > 0) begin
                e = sq.pop_front();
                m_we = 1'b1; m_waddr = e[10:8]; m_wdata = e[7:0]; m_busy = 1'b1;
            end else if (r != 0) begin
                for (int g = 0; g < NREQ; g++) begin
                    if (r[g]) begin
                        m_we = 1'b1;
                        m_waddr = req_addr[3*g +: 3];
                        m_wdata = req_data[8*g +: 8];
                        m_ptr = (g + 1) % NREQ;
                    end
                end
                m_busy = 1'b0;
            end else begin
                m_we = 1'b0;
                m_busy = 1'b0;
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        logic [W-1:0] act, exp;
        logic h1, h2;
        h1 = m_we && (rd1_addr == m_waddr);
        h2 = m_we && (rd2_addr == m_waddr);
        act = {req_ready, rf_we, rf_waddr, rf_wdata, scrub_busy,
               rd1_hazard, rd2_hazard, rd1_fwd, rd2_fwd};
        exp = {exp_ready(), m_we, m_waddr, m_wdata, m_busy, h1, h2,
               h1 ? m_wdata : 8'h00, h2 ? m_wdata : 8'h00};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act, exp);
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        reset = 1'b1; req_valid = '0; stall = 1'b0; scrub_start = 1'b0;
        scrub_value = 8'h00; rd1_addr = 3'd0; rd2_addr = 3'd0;
        req_addr = {3'd6, 3'd5, 3'd3};
        req_data = {8'h33, 8'hA7, 8'h11};
        req_valid = 3'b111;
        step(); step();
        chk("reset_we", 32'(rf_we), 0);
        chk("reset_ready", 32'(req_ready), 0);
        chk("reset_busy", 32'(scrub_busy), 0);
        chk("reset_waddr", 32'(rf_waddr), 0);

        // IDLE for one cycle after release, then fair rotation 0,1,2,0,1,2
        reset = 1'b0;
        #1 chk("idle_no_grant", 32'(req_ready), 0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("fair_%0d", c), 32'(req_ready), 32'(1 << (c % 3)));
        end
        step();
        req_valid = 3'b010;
        chk("wrap_we", 32'(rf_we), 1);
        chk("wrap_waddr", 32'(rf_waddr), 6);
        chk("wrap_wdata", 32'(rf_wdata), 32'h33);
        #1 chk("single_ready", 32'(req_ready), 32'b010);

        // Single requester 1: addr 5 / 0xA7, both read ports hit
        step();
        req_valid = 3'b000; rd1_addr = 3'd5; rd2_addr = 3'd5;
        #1;
        chk("single_we", 32'(rf_we), 1);
        chk("single_waddr", 32'(rf_waddr), 5);
        chk("single_wdata", 32'(rf_wdata), 32'hA7);
        chk("rd1_hazard", 32'(rd1_hazard), 1);
        chk("rd1_fwd", 32'(rd1_fwd), 32'hA7);
        chk("rd2_hazard_same", 32'(rd2_hazard), 1);
        rd2_addr = 3'd4;
        #1 chk("rd2_fwd_miss", 32'(rd2_fwd), 0);
        step();
        chk("idle_we", 32'(rf_we), 0);
        chk("idle_hazard", 32'(rd1_hazard), 0);

        // Stall: req0 writes 3/0x11, then three stalled cycles hold it
        req_valid = 3'b001;
        #1 chk("stall_pre_ready", 32'(req_ready), 32'b001);
        step();
        req_valid = 3'b110; stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("stall_we_%0d", s), 32'(rf_we), 1);
            chk($sformatf("stall_addr_%0d", s), 32'({rf_waddr, rf_wdata}), 32'h311);
            chk($sformatf("stall_ready_%0d", s), 32'(req_ready), 0);
            if (s < 2) step();
        end
        step();
        stall = 1'b0;
        #1 chk("resume_req1", 32'(req_ready), 32'b010);
        step();
        req_valid = 3'b100;

        // Scrub beats req2 on the start cycle, then writes 0..7 with 0x5A
        scrub_start = 1'b1; scrub_value = 8'h5A;
        #1 chk("scrub_no_grant", 32'(req_ready), 0);
        for (int a = 0; a < 8; a++) begin
            step();
            scrub_start = (a == 3);
            scrub_value = (a == 3) ? 8'hFF : 8'h5A;
            #1;
            chk($sformatf("scrub_busy_%0d", a), 32'(scrub_busy), 1);
            chk($sformatf("scrub_w_%0d", a), 32'({rf_we, rf_waddr, rf_wdata}),
                32'({1'b1, 3'(a), 8'h5A}));
            if (a < 7) chk($sformatf("scrub_ready_%0d", a), 32'(req_ready), 0);
        end
        step();
        chk("scrub_busy_end", 32'(scrub_busy), 0);
        chk("req2_after_scrub", 32'({rf_we, rf_waddr, rf_wdata}), 32'({1'b1, 3'd6, 8'h33}));
        req_valid = 3'b000;

        // Second scrub with a stall at address 2, then reset at address 4
        scrub_start = 1'b1; scrub_value = 8'hC3;
        step();
        scrub_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rf_we && rf_waddr == 3'd4) seen = 1'b1;
            else begin
                stall = (rf_waddr == 3'd2) && !stall;
                step();
            end
        end
        stall = 1'b0;
        chk("reach_addr4", 32'(seen), 1);
        req_valid = 3'b111;
        #2 reset = 1'b1;
        #1;
        chk("midscrub_we", 32'(rf_we), 0);
        chk("midscrub_addr_data", 32'({rf_waddr, rf_wdata}), 0);
        chk("midscrub_busy", 32'(scrub_busy), 0);
        chk("midscrub_ready", 32'(req_ready), 0);
        step();
        reset = 1'b0;
        #1 chk("post_reset_idle", 32'(req_ready), 0);
        step();
        chk("post_reset_ptr0", 32'(req_ready), 32'b001);
        chk("no_scrub_resume", 32'(scrub_busy), 0);
        step();
        req_valid = 3'b000;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
